// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared definitions for the dual-port RAM.
//   READ_FIRST / WRITE_FIRST : values for the WRITE_MODE parameter
//   state_e                  : init-sequencer states
//   merge()                  : byte-lane merge of new data into an old word
package dp_ram_pkg;

    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;

    // merge() works on a fixed wide word; callers zero-extend and truncate.
    localparam int unsigned MAX_W  = 256;
    localparam int unsigned MAX_BE = MAX_W / 8;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0]  old_w,
                                               input logic [MAX_W-1:0]  new_w,
                                               input logic [MAX_BE-1:0] be);
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MAX_BE); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_init_seq.sv
// dp_ram_init_seq: post-reset initialisation sweep for dual_port_ram_p.
//   clk, rst_n   : clock, asynchronous active-low reset
//   init_we_o    : write strobe for the sweep (high in INIT)
//   init_addr_o  : word address written by the sweep, 0..DEPTH-1
//   init_busy_o  : registered, high until the last word has been written
module dp_ram_init_seq
    import dp_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic              init_busy_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
        busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign init_we_o   = (state_q == INIT);
    assign init_addr_o = cnt_q;
    assign init_busy_o = busy_q;

endmodule

// File: rtl/dual_port_ram_p.sv
// dual_port_ram_p: true dual-port synchronous RAM with byte enables, RD_LAT 1 or 2,
// deterministic cross-port collision handling and a post-reset init sweep.
//   EN_x/WE_x/BE_x/ADDR_x/D_IN_x : port request (x = A, B)
//   Q_OUT_x, VALID_x             : read data, held until the next read completes
//   COLLISION                    : pulse aligned with the colliding request's read slot
//   INIT_BUSY                    : high while the sweep runs; requests ignored
module dual_port_ram_p
    import dp_ram_pkg::*;
#(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        ADDR_W     = 3,
    parameter int unsigned        RD_LAT     = 1,
    parameter int unsigned        WRITE_MODE = READ_FIRST,
    parameter logic [DATA_W-1:0]  INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EN_A,
    input  logic                  EN_B,
    input  logic                  WE_A,
    input  logic                  WE_B,
    input  logic [DATA_W/8-1:0]   BE_A,
    input  logic [DATA_W/8-1:0]   BE_B,
    input  logic [ADDR_W-1:0]     ADDR_A,
    input  logic [ADDR_W-1:0]     ADDR_B,
    input  logic [DATA_W-1:0]     D_IN_A,
    input  logic [DATA_W-1:0]     D_IN_B,
    output logic [DATA_W-1:0]     Q_OUT_A,
    output logic [DATA_W-1:0]     Q_OUT_B,
    output logic                  VALID_A,
    output logic                  VALID_B,
    output logic                  COLLISION,
    output logic                  INIT_BUSY
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned BE_W  = DATA_W / 8;

    if ((DATA_W % 8) != 0 || DATA_W > MAX_W) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8 and no wider than %0d", MAX_W);
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("RD_LAT must be 1 or 2");
    end

    function automatic logic [DATA_W-1:0] merge_w(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [BE_W-1:0]   be);
        return DATA_W'(merge(MAX_W'(old_w), MAX_W'(new_w), MAX_BE'(be)));
    endfunction

    logic              init_we;
    logic              init_busy;
    logic [ADDR_W-1:0] init_addr;

    dp_ram_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .init_busy_o (init_busy)
    );

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              rd_a, rd_b, wr_a, wr_b, coll;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    always_comb begin
        rd_a = !init_busy && EN_A && !WE_A;
        rd_b = !init_busy && EN_B && !WE_B;
        // An all-zero byte mask is a no-op and must not flag a collision.
        wr_a = !init_busy && EN_A && WE_A && (|BE_A);
        wr_b = !init_busy && EN_B && WE_B && (|BE_B);
        coll = !init_busy && EN_A && EN_B && (ADDR_A == ADDR_B) && (wr_a || wr_b);
    end

    always_comb begin
        mem_d = mem_q;
        if (init_we) begin
            mem_d[init_addr] = INIT_VAL;
        end else begin
            if (wr_b) begin
                mem_d[ADDR_B] = merge_w(mem_d[ADDR_B], D_IN_B, BE_B);
            end
            // Port A is applied last so it owns bytes enabled on both ports.
            if (wr_a) begin
                mem_d[ADDR_A] = merge_w(mem_d[ADDR_A], D_IN_A, BE_A);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // WRITE_FIRST reads see the other port's same-cycle write via mem_d.
    always_comb begin
        if (WRITE_MODE == WRITE_FIRST) begin
            rdata_a = mem_d[ADDR_A];
            rdata_b = mem_d[ADDR_B];
        end else begin
            rdata_a = mem_q[ADDR_A];
            rdata_b = mem_q[ADDR_B];
        end
    end

    logic              s1_va_q, s1_va_d, s1_vb_q, s1_vb_d, s1_c_q, s1_c_d;
    logic [DATA_W-1:0] s1_qa_q, s1_qa_d, s1_qb_q, s1_qb_d;

    always_comb begin
        s1_va_d = rd_a;
        s1_vb_d = rd_b;
        s1_c_d  = coll;
        s1_qa_d = rd_a ? rdata_a : s1_qa_q;
        s1_qb_d = rd_b ? rdata_b : s1_qb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_va_q <= 1'b0;
            s1_vb_q <= 1'b0;
            s1_c_q  <= 1'b0;
            s1_qa_q <= '0;
            s1_qb_q <= '0;
        end else begin
            s1_va_q <= s1_va_d;
            s1_vb_q <= s1_vb_d;
            s1_c_q  <= s1_c_d;
            s1_qa_q <= s1_qa_d;
            s1_qb_q <= s1_qb_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_va_q, s2_vb_q, s2_c_q;
        logic [DATA_W-1:0] s2_qa_q, s2_qa_d, s2_qb_q, s2_qb_d;

        always_comb begin
            s2_qa_d = s1_va_q ? s1_qa_q : s2_qa_q;
            s2_qb_d = s1_vb_q ? s1_qb_q : s2_qb_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_va_q <= 1'b0;
                s2_vb_q <= 1'b0;
                s2_c_q  <= 1'b0;
                s2_qa_q <= '0;
                s2_qb_q <= '0;
            end else begin
                s2_va_q <= s1_va_q;
                s2_vb_q <= s1_vb_q;
                s2_c_q  <= s1_c_q;
                s2_qa_q <= s2_qa_d;
                s2_qb_q <= s2_qb_d;
            end
        end

        assign Q_OUT_A   = s2_qa_q;
        assign Q_OUT_B   = s2_qb_q;
        assign VALID_A   = s2_va_q;
        assign VALID_B   = s2_vb_q;
        assign COLLISION = s2_c_q;
    end else begin : g_lat1
        assign Q_OUT_A   = s1_qa_q;
        assign Q_OUT_B   = s1_qb_q;
        assign VALID_A   = s1_va_q;
        assign VALID_B   = s1_vb_q;
        assign COLLISION = s1_c_q;
    end

    assign INIT_BUSY = init_busy;

endmodule

// File: tb/tb_dual_port_ram_p.sv
// tb_dual_port_ram_p: two DUTs on shared stimulus (RD_LAT=1/READ_FIRST with INIT_VAL=0,
// RD_LAT=2/WRITE_FIRST with a non-zero INIT_VAL) checked against a word-array model.
module tb_dual_port_ram_p;

    localparam int          DEPTH = 8;
    localparam int          NB    = 4;
    localparam logic [31:0] IV0   = 32'h0000_0000;
    localparam logic [31:0] IV1   = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [2:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic [31:0] q_a0, q_b0, q_a1, q_b1;
    logic        va0, vb0, c0, bz0, va1, vb1, c1, bz1;

    always #5 clk = ~clk;

    dual_port_ram_p #(
        .DATA_W(32), .ADDR_W(3), .RD_LAT(1), .WRITE_MODE(0), .INIT_VAL(IV0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .EN_A(en_a), .EN_B(en_b), .WE_A(we_a), .WE_B(we_b),
        .BE_A(be_a), .BE_B(be_b), .ADDR_A(addr_a), .ADDR_B(addr_b), .D_IN_A(din_a),
        .D_IN_B(din_b), .Q_OUT_A(q_a0), .Q_OUT_B(q_b0), .VALID_A(va0), .VALID_B(vb0),
        .COLLISION(c0), .INIT_BUSY(bz0)
    );

    dual_port_ram_p #(
        .DATA_W(32), .ADDR_W(3), .RD_LAT(2), .WRITE_MODE(1), .INIT_VAL(IV1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .EN_A(en_a), .EN_B(en_b), .WE_A(we_a), .WE_B(we_b),
        .BE_A(be_a), .BE_B(be_b), .ADDR_A(addr_a), .ADDR_B(addr_b), .D_IN_A(din_a),
        .D_IN_B(din_b), .Q_OUT_A(q_a1), .Q_OUT_B(q_b1), .VALID_A(va1), .VALID_B(vb1),
        .COLLISION(c1), .INIT_BUSY(bz1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        va;
        logic        vb;
        logic        c;
        logic [31:0] da;
        logic [31:0] db;
    } res_t;

    logic [31:0] mem [2][DEPTH];
    int          init_cnt;
    res_t        prev [2];
    logic [31:0] eqa [2], eqb [2];
    logic        eva [2], evb [2], ec [2];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Contents of word x after this edge: each byte comes from A if A writes it,
    // else from B if B writes it, else keeps its old value.
    function automatic logic [31:0] word_after(input logic [31:0] old_w, input logic [2:0] x);
        logic [31:0] w;
        w = old_w;
        for (int i = 0; i < NB; i++) begin
            if (en_a && we_a && addr_a == x && be_a[i])      w[8*i +: 8] = din_a[8*i +: 8];
            else if (en_b && we_b && addr_b == x && be_b[i]) w[8*i +: 8] = din_b[8*i +: 8];
        end
        return w;
    endfunction

    task automatic model_reset();
        init_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            prev[k] = '0;
            eqa[k]  = '0;
            eqb[k]  = '0;
            eva[k]  = 1'b0;
            evb[k]  = 1'b0;
            ec[k]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        res_t        cur, out;
        logic [31:0] post_a, post_b;
        for (int k = 0; k < 2; k++) begin
            cur = '0;
            if (init_cnt < DEPTH) begin
                mem[k][init_cnt] = (k == 0) ? IV0 : IV1;
            end else begin
                post_a = word_after(mem[k][addr_a], addr_a);
                post_b = word_after(mem[k][addr_b], addr_b);
                if (en_a && !we_a) begin
                    cur.va = 1'b1;
                    cur.da = (k == 1) ? post_a : mem[k][addr_a];
                end
                if (en_b && !we_b) begin
                    cur.vb = 1'b1;
                    cur.db = (k == 1) ? post_b : mem[k][addr_b];
                end
                cur.c = en_a && en_b && addr_a == addr_b &&
                        ((we_a && be_a != 0) || (we_b && be_b != 0));
                mem[k][addr_a] = post_a;
                mem[k][addr_b] = post_b;
            end
            // Instance 0 reports one edge after the request, instance 1 two edges.
            out     = (k == 0) ? cur : prev[k];
            prev[k] = cur;
            eva[k]  = out.va;
            evb[k]  = out.vb;
            ec[k]   = out.c;
            if (out.va) eqa[k] = out.da;
            if (out.vb) eqb[k] = out.db;
        end
        if (init_cnt < DEPTH) init_cnt++;
    endtask

    task automatic compare_all();
        logic [31:0] oqa [2], oqb [2];
        logic        ova [2], ovb [2], oc [2], obz [2];
        logic        busy_exp;
        oqa[0] = q_a0; oqb[0] = q_b0; ova[0] = va0; ovb[0] = vb0; oc[0] = c0; obz[0] = bz0;
        oqa[1] = q_a1; oqb[1] = q_b1; ova[1] = va1; ovb[1] = vb1; oc[1] = c1; obz[1] = bz1;
        busy_exp = (init_cnt < DEPTH);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("u%0d.valid_a", k), {31'd0, ova[k]}, {31'd0, eva[k]});
            check_eq($sformatf("u%0d.valid_b", k), {31'd0, ovb[k]}, {31'd0, evb[k]});
            check_eq($sformatf("u%0d.q_out_a", k), oqa[k], eqa[k]);
            check_eq($sformatf("u%0d.q_out_b", k), oqb[k], eqb[k]);
            check_eq($sformatf("u%0d.collision", k), {31'd0, oc[k]}, {31'd0, ec[k]});
            check_eq($sformatf("u%0d.init_busy", k), {31'd0, obz[k]}, {31'd0, busy_exp});
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic ea, input logic wa, input logic [3:0] ba,
                         input logic [2:0] aa, input logic [31:0] da,
                         input logic eb, input logic wb, input logic [3:0] bb,
                         input logic [2:0] ab, input logic [31:0] db);
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 3'd0, 32'h0, 0, 0, 4'h0, 3'd0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic flush();
        idle();
        step();
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    logic [31:0] wa_vals [4];
    logic [31:0] wb_vals [4];

    initial begin
        wa_vals = '{32'h15, 32'h16, 32'h17, 32'h18};
        wb_vals = '{32'h19, 32'h20, 32'h21, 32'h22};
        idle();
        @(negedge clk);
        apply_reset();

        // Init sweep: INIT_BUSY high for DEPTH edges.
        for (int i = 0; i < DEPTH; i++) step();
        check_eq("busy_after_sweep", {31'd0, bz0}, 32'd0);

        // Read back every address on port A (back-to-back).
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 4'h0, 3'(i), 32'h0, 0, 0, 4'h0, 3'd0, 32'h0);
            step();
        end
        flush();
        check_eq("init_word7_u1", q_a1, IV1);

        // Parallel writes, then cross reads.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'hF, 3'(i), wa_vals[i], 1, 1, 4'hF, 3'(i + 4), wb_vals[i]);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4'h0, 3'(i + 4), 32'h0, 1, 0, 4'h0, 3'(i), 32'h0);
            step();
        end
        flush();
        check_eq("cross_a_u0", q_a0, 32'h22);
        check_eq("cross_b_u1", q_b1, 32'h18);

        // Byte-enable merge.
        drive(1, 1, 4'hF, 3'd2, 32'hAABB_CCDD, 0, 0, 4'h0, 3'd0, 32'h0);
        step();
        drive(1, 1, 4'h5, 3'd2, 32'h1122_3344, 0, 0, 4'h0, 3'd0, 32'h0);
        step();
        drive(1, 0, 4'h0, 3'd2, 32'h0, 0, 0, 4'h0, 3'd0, 32'h0);
        step();
        flush();
        check_eq("be_merge_u0", q_a0, 32'hAA22_CC44);
        check_eq("be_merge_u1", q_a1, 32'hAA22_CC44);

        // Dual write on address 5: single-cycle COLLISION pulse.
        drive(1, 1, 4'h3, 3'd5, 32'h0000_FFFF, 1, 1, 4'hF, 3'd5, 32'h1234_5678);
        step();
        check_eq("dual_coll_u0", {31'd0, c0}, 32'd1);
        idle();
        step();
        check_eq("dual_coll_end_u0", {31'd0, c0}, 32'd0);
        check_eq("dual_coll_u1", {31'd0, c1}, 32'd1);
        step();
        check_eq("dual_coll_end_u1", {31'd0, c1}, 32'd0);
        drive(1, 0, 4'h0, 3'd5, 32'h0, 0, 0, 4'h0, 3'd0, 32'h0);
        step();
        flush();
        check_eq("dual_word_u0", q_a0, 32'h1234_FFFF);
        check_eq("dual_word_u1", q_a1, 32'h1234_FFFF);

        // Read/write collision on address 3 (holds 0x18).
        drive(1, 1, 4'hF, 3'd3, 32'h99, 1, 0, 4'h0, 3'd3, 32'h0);
        step();
        check_eq("rw_coll_u0", {31'd0, c0}, 32'd1);
        check_eq("rw_read_first_u0", q_b0, 32'h18);
        idle();
        step();
        check_eq("rw_coll_u1", {31'd0, c1}, 32'd1);
        check_eq("rw_write_first_u1", q_b1, 32'h99);
        flush();

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rba, rbb;
            rba = 4'($urandom);
            rbb = 4'($urandom);
            if ($urandom_range(0, 7) == 0) rba = 4'h0;
            if ($urandom_range(0, 7) == 0) rbb = 4'h0;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), rba, 3'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom), rbb, 3'($urandom), $urandom);
            step();
        end
        flush();

        // Reset with a read in flight on the two-cycle instance.
        drive(1, 0, 4'h0, 3'd0, 32'h0, 1, 0, 4'h0, 3'd1, 32'h0);
        step();
        idle();
        apply_reset();
        check_eq("rst_valid_u1", {31'd0, va1}, 32'd0);
        check_eq("rst_q_u1", q_a1, 32'd0);
        check_eq("rst_busy_u1", {31'd0, bz1}, 32'd1);
        for (int i = 0; i < DEPTH; i++) step();
        drive(1, 0, 4'h0, 3'd0, 32'h0, 0, 0, 4'h0, 3'd0, 32'h0);
        step();
        flush();
        check_eq("resweep_u0", q_a0, IV0);
        check_eq("resweep_u1", q_a1, IV1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_p.md
# dual_port_ram_p

Parametrised true dual-port synchronous RAM with per-port enables, byte-write enables and selectable read latency. It adds deterministic cross-port collision resolution and a post-reset initialisation sweep that writes a known value to every word. It sits between two independent bus masters (ports A and B) sharing one storage array in the same clock domain, and supersedes the fixed 32x8 dual-port RAM.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2
- WRITE_MODE, 0, read-during-cross-port-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST
- INIT_VAL, 0, DATA_W-bit value written to every word by the init sweep

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- EN_A, EN_B  in  1  port request enable
- WE_A, WE_B  in  1  write (1) or read (0) when EN is high
- BE_A, BE_B  in  DATA_W/8  byte write enables; bit i covers bits 8i+7:8i
- ADDR_A, ADDR_B  in  ADDR_W  word address
- D_IN_A, D_IN_B  in  DATA_W  write data
- Q_OUT_A, Q_OUT_B  out  DATA_W  read data
- VALID_A, VALID_B  out  1  single-cycle pulse marking Q_OUT as new read data
- COLLISION  out  1  single-cycle pulse for a cross-port address conflict
- INIT_BUSY  out  1  high while the init sweep runs; all port requests are ignored

## Operation
- Reset values: Q_OUT_A and Q_OUT_B = 0, VALID_A and VALID_B = 0, COLLISION = 0, INIT_BUSY = 1, init counter = 0, FSM = INIT.
- FSM state INIT: writes INIT_VAL to address cnt on each cycle, with cnt running 0..DEPTH-1. After cnt = DEPTH-1 is written, the FSM moves to RUN and INIT_BUSY falls.
- FSM state RUN: port requests are accepted. RUN is left only through reset.
- Read: EN=1, WE=0. The addressed word appears on Q_OUT with VALID=1 after RD_LAT cycles. Q_OUT holds its value until the next read completes.
- Write: EN=1, WE=1. Only bytes with BE=1 are updated. A write never produces a VALID pulse.
- A write with BE all zero changes no memory and is not counted as a write for collision purposes.
- Collision condition: EN_A=EN_B=1, ADDR_A=ADDR_B, and at least one port performs an effective write. COLLISION pulses in the same cycle as VALID would for that request, i.e. RD_LAT cycles later.
- Both ports write: bytes enabled on only one port take that port's data. Bytes enabled on both ports take port A's data (port A wins).
- One port writes, the other reads: the reader returns the pre-write word in READ_FIRST mode. In WRITE_FIRST mode it returns the post-write word, i.e. old data merged with the writer's enabled bytes.
- Both ports read the same address: this is not a collision, and both ports return the same data.
- Same-port read-after-write on consecutive cycles returns the newly written data.
- Reset mid-operation: all outputs return to their reset values immediately. In-flight read pipeline stages are discarded and never raise VALID. The init sweep restarts from address 0 after rst_n rises.

## Timing
- rst_n is asserted asynchronously and released synchronously to clk by the integrator.
- Init sweep: the first clk edge with rst_n=1 writes address 0. INIT_BUSY is low after edge number DEPTH (8 edges with default ADDR_W). A request must not be presented until the first edge at which INIT_BUSY is sampled low; it is accepted at that edge.
- RD_LAT=1: a request sampled at edge k updates Q_OUT, VALID and COLLISION after edge k, and they are visible during cycle k+1.
- RD_LAT=2: the same outputs update after edge k+1. The pipeline is fully registered with throughput of one request per port per cycle.
- Back-to-back reads on every cycle give VALID held high continuously.

## Structure
- Package dp_ram_pkg holds:
  - constants READ_FIRST=0 and WRITE_FIRST=1
  - FSM state typedef {INIT, RUN}
  - a byte-merge function merge(old, new, be)
- Sub-module dp_ram_init_seq contains the INIT/RUN FSM and address counter, and outputs init_we, init_addr and INIT_BUSY.
- The top level contains the storage array, per-port read pipelines, collision compare and the registered collision flag.
- Parameter checks are elaborated: DATA_W%8==0 and RD_LAT in {1,2}.

## Test plan
- Reset then wait: INIT_BUSY stays high for 8 edges. Then reading addresses 0..7 on port A returns 0x00000000 with one VALID pulse each, and COLLISION stays 0.
- Port A writes 0x15, 0x16, 0x17, 0x18 to addresses 0..3 while port B writes 0x19, 0x20, 0x21, 0x22 to addresses 4..7. Cross-reading (A reads 4..7, B reads 0..3) returns the matching values at latency RD_LAT, for both RD_LAT=1 and RD_LAT=2.
- Byte enables: address 2 holds 0xAABBCCDD. A writes 0x11223344 with BE=0101, then A reads address 2 and gets 0xAA22CC44.
- Dual write to address 5: A writes 0x0000FFFF with BE=0011, B writes 0x12345678 with BE=1111. A later read gets 0x1234FFFF, and COLLISION=1 for exactly one cycle.
- Read/write collision on address 3 holding 0x18: A writes 0x99 while B reads address 3. B gets 0x18 in READ_FIRST mode and 0x99 in WRITE_FIRST mode, and COLLISION pulses in both modes.
- Reset asserted mid-read (RD_LAT=2) with one read in flight: no VALID pulse occurs, Q_OUT=0, INIT_BUSY=1, and the sweep reruns so a read of address 0 returns INIT_VAL.
